// File: rtl/sr_bank_sequencer.sv
// sr_bank_sequencer: round-robin arbiter for two set/reset requesters. It walks a gated
// SR-latch bank through setup / enable / hold and then reads the bank back to confirm the write.
module sr_bank_sequencer #(
    parameter int W     = 8,
    parameter int PULSE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] s_mask0,
    input  logic [W-1:0] s_mask1,
    input  logic [W-1:0] r_mask0,
    input  logic [W-1:0] r_mask1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         err0,
    output logic         err1,
    output logic [W-1:0] latch_s,
    output logic [W-1:0] latch_r,
    output logic         latch_e,
    input  logic [W-1:0] q_in,
    output logic         busy,
    output logic         done,
    output logic         fail
);
    localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, EN, HOLD, CHECK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [W-1:0]  s_q, s_d, r_q, r_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [W-1:0]  latch_s_q, latch_s_d, latch_r_q, latch_r_d;
    logic          latch_e_q, latch_e_d, busy_q, busy_d;
    logic          done_q, done_d, fail_q, fail_d;
    logic          inv0, inv1, val0, val1, win0, win1;

    // A request that asks to set and reset the same bit is rejected; last_q=1 favours requester 0.
    assign inv0 = req0 && ((s_mask0 & r_mask0) != '0);
    assign inv1 = req1 && ((s_mask1 & r_mask1) != '0);
    assign val0 = req0 && !inv0;
    assign val1 = req1 && !inv1;
    assign win0 = val0 && (!val1 || last_q);
    assign win1 = val1 && (!val0 || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            s_q       <= '0;
            r_q       <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            latch_s_q <= '0;
            latch_r_q <= '0;
            latch_e_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            s_q       <= s_d;
            r_q       <= r_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            latch_s_q <= latch_s_d;
            latch_r_q <= latch_r_d;
            latch_e_q <= latch_e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        s_d     = s_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (win0 || win1) begin
                    state_d = SETUP;
                    last_d  = win1;
                    s_d     = win0 ? s_mask0 : s_mask1;
                    r_d     = win0 ? r_mask0 : r_mask1;
                end
            end
            SETUP: begin
                state_d = EN;
                cnt_d   = '0;
            end
            EN: begin
                if (cnt_q == CW'(PULSE - 1)) state_d = HOLD;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            HOLD:    state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that every port comes straight from a flop.
    always_comb begin
        gnt0_d    = (state_q == IDLE) && win0;
        gnt1_d    = (state_q == IDLE) && win1;
        err0_d    = (state_q == IDLE) && inv0;
        err1_d    = (state_q == IDLE) && inv1;
        latch_s_d = '0;
        latch_r_d = '0;
        if (state_d == SETUP || state_d == EN || state_d == HOLD) begin
            latch_s_d = s_d;
            latch_r_d = r_d;
        end
        latch_e_d = (state_d == EN);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == CHECK);
        fail_d    = (state_q == CHECK) && (((s_q & ~q_in) | (r_q & q_in)) != '0);
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign latch_s = latch_s_q;
    assign latch_r = latch_r_q;
    assign latch_e = latch_e_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_sr_bank_sequencer.sv
// Randomised and directed bench for sr_bank_sequencer. A transaction-level model predicts
// every output from the cycle offset since the grant, and a small SR-latch bank drives q_in.
module tb_sr_bank_sequencer;
    localparam int W     = 8;
    localparam int PULSE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] s_mask0 = '0, s_mask1 = '0, r_mask0 = '0, r_mask1 = '0;
    logic         gnt0, gnt1, err0, err1, latch_e, busy, done, fail;
    logic [W-1:0] latch_s, latch_r, q_in;

    bit   [W-1:0] latchQ = '0;
    bit           qOverrideEn = 1'b0;
    bit   [W-1:0] qOverrideVal = '0;
    int           cyc = 0;
    int           checks = 0;
    int           passes = 0;

    sr_bank_sequencer #(.W(W), .PULSE(PULSE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .s_mask0(s_mask0), .s_mask1(s_mask1),
        .r_mask0(r_mask0), .r_mask1(r_mask1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .latch_s(latch_s), .latch_r(latch_r), .latch_e(latch_e),
        .q_in(q_in), .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The bank: each latch follows S/R while enable is high and keeps its value otherwise.
    always @(negedge clk) if (latch_e) latchQ <= (latchQ & ~latch_r) | latch_s;
    assign q_in = qOverrideEn ? qOverrideVal : latchQ;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model state: the active transaction, its cycle offset k from the grant, and the round-robin pointer.
    bit           mActive = 1'b0, mLast = 1'b1;
    int           mK = 0;
    bit   [W-1:0] mS = '0, mR = '0, mLatch = '0, qRef;
    bit           eGnt0, eGnt1, eErr0, eErr1, eBusy, eDone, eFail, eE;
    bit   [W-1:0] eS, eR;
    bit           i0, i1, v0, v1, pick0;

    task automatic modelStep();
        {eGnt0, eGnt1, eErr0, eErr1, eBusy, eDone, eFail, eE} = '0;
        eS = '0;
        eR = '0;
        if (!rst_n) begin
            mActive = 1'b0;
            mLast   = 1'b1;
            mK      = 0;
        end else begin
            if (mActive) mK++;
            if (!mActive || mK >= PULSE + 4) begin
                mActive = 1'b0;
                i0 = req0 && ((s_mask0 & r_mask0) != 0);
                i1 = req1 && ((s_mask1 & r_mask1) != 0);
                v0 = req0 && !i0;
                v1 = req1 && !i1;
                eErr0 = i0;
                eErr1 = i1;
                if (v0 || v1) begin
                    pick0   = v0 && (!v1 || mLast);
                    mLast   = !pick0;
                    eGnt0   = pick0;
                    eGnt1   = !pick0;
                    mS      = pick0 ? s_mask0 : s_mask1;
                    mR      = pick0 ? r_mask0 : r_mask1;
                    mActive = 1'b1;
                    mK      = 0;
                end
            end
            if (mActive) begin
                if (mK == 1) mLatch = (mLatch & ~mR) | mS;
                eBusy = (mK <= PULSE + 2);
                eE    = (mK >= 1 && mK <= PULSE);
                if (mK <= PULSE + 1) begin
                    eS = mS;
                    eR = mR;
                end
                if (mK == PULSE + 3) begin
                    qRef  = qOverrideEn ? qOverrideVal : mLatch;
                    eDone = 1'b1;
                    eFail = ((mS & ~qRef) | (mR & qRef)) != 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) modelStep();

    logic [8+2*W-1:0] actPack, expPack;
    assign actPack = {gnt0, gnt1, err0, err1, busy, done, fail, latch_e, latch_s, latch_r};
    assign expPack = {eGnt0, eGnt1, eErr0, eErr1, eBusy, eDone, eFail, eE, eS, eR};

    bit [W-1:0] prevS = '0, prevR = '0;

    // Every cycle: the full output bundle against the model, plus the latch-safety rules.
    always @(negedge clk) begin
        checkOutput("cycle outputs", actPack, expPack);
        checkOutput("S and R both high", latch_s & latch_r, '0);
        checkOutput("S/R moved while enabled",
                    latch_e && (latch_s != prevS || latch_r != prevR), '0);
        prevS <= latch_s;
        prevR <= latch_r;
    end

    task automatic applyStimulus(input logic rq0, input logic [W-1:0] s0, input logic [W-1:0] r0,
                                 input logic rq1, input logic [W-1:0] s1, input logic [W-1:0] r1);
        req0 = rq0; s_mask0 = s0; r_mask0 = r0;
        req1 = rq1; s_mask1 = s1; r_mask1 = r1;
    endtask

    task automatic waitGrant(output int atCycle, output logic [1:0] who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0 || gnt1) && n < 40);
        checkOutput("grant seen", gnt0 || gnt1, 1'b1);
        atCycle = cyc;
        who = {gnt1, gnt0};
    endtask

    task automatic pickMasks(output logic [W-1:0] s, output logic [W-1:0] r);
        int kind, b;
        kind = $urandom_range(0, 7);
        s = W'($urandom);
        r = W'($urandom);
        if (kind == 0) begin
            b = $urandom_range(0, W - 1);
            s[b] = 1'b1;
            r[b] = 1'b1;
        end else if (kind == 1) begin
            s = '0;
            r = '0;
        end else begin
            r = r & ~s;
        end
    endtask

    int          t0, t1;
    logic [1:0]  g;
    logic [W-1:0] ms, mr;
    bit   [5:0]  eSeq, doneSeq;

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("outputs in reset", actPack, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single set of 0x05: enable in cycles 1-2, clean done in cycle 5.
        eSeq    = 6'b000110;
        doneSeq = 6'b100000;
        applyStimulus(1, 8'h05, 8'h00, 0, 8'h00, 8'h00);
        waitGrant(t0, g);
        checkOutput("single set grant", g, 2'b01);
        req0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("single set enable", latch_e, eSeq[k]);
            checkOutput("single set done", done, doneSeq[k]);
        end
        checkOutput("single set fail", fail, 1'b0);
        checkOutput("single set readback", q_in, 8'h05);
        repeat (2) @(negedge clk);

        // Fresh reset, then two contentions in a row alternate 0 then 1, six cycles apart.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 8'h10, 8'h00, 1, 8'h20, 8'h00);
        waitGrant(t0, g);
        checkOutput("first contention winner", g, 2'b01);
        waitGrant(t1, g);
        checkOutput("second contention winner", g, 2'b10);
        checkOutput("contention grant spacing", t1 - t0, 6);
        applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        repeat (8) @(negedge clk);

        // Invalid request 1 errors in the same cycle that requester 0 is granted, and again next idle.
        applyStimulus(1, 8'h80, 8'h00, 1, 8'h01, 8'h01);
        @(negedge clk);
        checkOutput("gnt0/err1 together", {gnt0, gnt1, err0, err1}, 4'b1001);
        req0 = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("err1 repeats at next idle", {gnt0, gnt1, err0, err1}, 4'b0001);
        req1 = 1'b0;
        repeat (8) @(negedge clk);

        // Readback failure with the bank stuck at zero, then success with bit 1 present.
        qOverrideEn  = 1'b1;
        qOverrideVal = 8'h00;
        applyStimulus(1, 8'h02, 8'h00, 0, 8'h00, 8'h00);
        waitGrant(t0, g);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stuck readback done/fail", {done, fail}, 2'b11);
        repeat (3) @(negedge clk);
        qOverrideVal = 8'h02;
        req0 = 1'b1;
        waitGrant(t0, g);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("good readback done/fail", {done, fail}, 2'b10);
        qOverrideEn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of enable, then requester 0 must win the first contention.
        applyStimulus(1, 8'h08, 8'h00, 0, 8'h00, 8'h00);
        waitGrant(t0, g);
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("enable high before abort", latch_e, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async reset clears outputs", actPack, '0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 8'h01, 8'h00, 1, 8'h02, 8'h00);
        waitGrant(t0, g);
        checkOutput("post-reset contention winner", g, 2'b01);
        applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        repeat (8) @(negedge clk);

        // Request raised during enable waits until the edge that ends the done cycle.
        applyStimulus(1, 8'h04, 8'h00, 0, 8'h00, 8'h00);
        waitGrant(t0, g);
        req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; s_mask1 = 8'h08; r_mask1 = 8'h00;
        waitGrant(t1, g);
        checkOutput("busy-time request winner", g, 2'b10);
        checkOutput("busy-time request spacing", t1 - t0, 6);
        req1 = 1'b0;
        repeat (8) @(negedge clk);

        // Random traffic: requesters hold until granted or rejected; readback is sometimes forced.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (req0 && (gnt0 || err0)) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                pickMasks(ms, mr);
                s_mask0 = ms; r_mask0 = mr; req0 = 1'b1;
            end
            if (req1 && (gnt1 || err1)) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                pickMasks(ms, mr);
                s_mask1 = ms; r_mask1 = mr; req1 = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) begin
                qOverrideEn  = ($urandom_range(0, 1) == 1);
                qOverrideVal = W'($urandom);
            end
        end
        applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        qOverrideEn = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
